// File: rtl/ksa_seq_pkg.sv
// Shared types and helpers for the serial byte-adder sequencer (ksa_word_seq_arb).
// Optional overflow output is controlled by the KSA_SEQ_OVF_EN macro in the top.
package ksa_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // Index width: max(1, clog2(n)), so a 2-entry (or 1-entry) range still gets one bit.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanned upward from a rotating pointer,
// pointer advances past the winner only when the grant is actually accepted.
module rr_arbiter
    import ksa_seq_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IDW   = calc_idw(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             accept_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDW-1:0]   grant_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic           found;
    int             idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (grant_idx_o == IDW'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ksa_word_seq_arb.sv
// Shares one external 8-bit adder between N_REQ requesters: arbitrates, runs WORDS
// byte passes LSB first with a registered carry, and returns one response per request.
// Define KSA_SEQ_OVF_EN to add the rsp_ovf two's-complement overflow output.
module ksa_word_seq_arb
    import ksa_seq_pkg::*;
#(
    parameter  int WORDS = 4,
    parameter  int N_REQ = 2,
    localparam int OPW   = BYTE_W * WORDS,
    localparam int IDW   = calc_idw(N_REQ),
    localparam int IXW   = calc_idw(WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*OPW-1:0] req_a,
    input  logic [N_REQ*OPW-1:0] req_b,
    input  logic [N_REQ-1:0]     req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [OPW-1:0]       rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [BYTE_W-1:0]    add_a,
    output logic [BYTE_W-1:0]    add_b,
    output logic                 add_cin,
    input  logic [BYTE_W-1:0]    add_sum,
    input  logic                 add_cout,
`ifdef KSA_SEQ_OVF_EN
    output logic                 rsp_ovf,
`endif
    output seq_state_e           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; requests are offered only in IDLE, and the response is held until taken.

    seq_state_e     state_q, state_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [OPW-1:0] sum_q, sum_d;
    logic           carry_q, carry_d;
    logic [IXW-1:0] idx_q, idx_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q, busy_d;
`ifdef KSA_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             last_byte;

    assign arb_req   = (state_q == IDLE && !rst) ? req_valid : '0;
    assign req_ready = grant;
    assign accept    = |(req_valid & req_ready);
    assign last_byte = (idx_q == IXW'(WORDS - 1));

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (arb_req),
        .accept_i   (accept),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    // The adder port is only live during byte passes so it idles at zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
            add_b   = b_q[int'(idx_q)*BYTE_W +: BYTE_W];
            add_cin = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        id_d    = id_q;
`ifdef KSA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = req_a[int'(grant_idx)*OPW +: OPW];
                    b_d     = req_b[int'(grant_idx)*OPW +: OPW];
                    carry_d = req_cin[grant_idx];
                    id_d    = grant_idx;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*BYTE_W +: BYTE_W] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    state_d = RESP;
`ifdef KSA_SEQ_OVF_EN
                    ovf_d = (a_q[OPW-1] == b_q[OPW-1]) && (add_sum[BYTE_W-1] != a_q[OPW-1]);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KSA_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef KSA_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // After the last pass carry_q holds the top byte's carry-out.
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;
    assign dbg_state = state_q;
`ifdef KSA_SEQ_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_ksa_word_seq_arb.sv
// Bench for ksa_word_seq_arb (WORDS=4, N_REQ=2) with a behavioural adder on the add_* port.
// Build with KSA_SEQ_OVF_EN defined to also check rsp_ovf.
`timescale 1ns/1ps
module tb_ksa_word_seq_arb;
    import ksa_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int N_REQ = 2;
    localparam int OPW   = 8 * WORDS;
    localparam int IDW   = 1;
    localparam int RW    = IDW + 2 + OPW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*OPW-1:0] req_a;
    logic [N_REQ*OPW-1:0] req_b;
    logic [N_REQ-1:0]     req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [OPW-1:0]       rsp_sum;
    logic                 rsp_cout;
    logic                 busy;
    logic [7:0]           add_a;
    logic [7:0]           add_b;
    logic                 add_cin;
    logic [7:0]           add_sum;
    logic                 add_cout;
`ifdef KSA_SEQ_OVF_EN
    logic                 rsp_ovf;
`endif
    seq_state_e           dbg_state;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    ksa_word_seq_arb #(
        .WORDS(WORDS),
        .N_REQ(N_REQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
`ifdef KSA_SEQ_OVF_EN
        .rsp_ovf  (rsp_ovf),
`endif
        .dbg_state(dbg_state)
    );

    int             checks   = 0;
    int             failures = 0;
    logic [RW-1:0]  exp_q[$];
    logic [OPW-1:0] op_a[N_REQ];
    logic [OPW-1:0] op_b[N_REQ];
    logic           op_cin[N_REQ];
    int             rr_ptr = 0;

    typedef struct {
        int             id;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
        logic [OPW-1:0] sum;
        logic           cout;
        logic           ovf;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*OPW +: OPW] = op_a[i];
            req_b[i*OPW +: OPW] = op_b[i];
            req_cin[i]          = op_cin[i];
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i]   = $urandom;
            op_b[i]   = $urandom;
            op_cin[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Round-robin reference: first valid index at or after rr_ptr, with wrap.
    function automatic int model_grant(input logic [N_REQ-1:0] m);
        int i;
        for (int k = 0; k < N_REQ; k++) begin
            i = (rr_ptr + k) % N_REQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] model_rsp(input int id, input logic [OPW-1:0] a,
                                                input logic [OPW-1:0] b, input logic cin);
        logic [OPW:0] full;
        logic         ovf;
        full = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, cin};
        ovf  = (a[OPW-1] == b[OPW-1]) && (full[OPW-1] != a[OPW-1]);
        return {IDW'(id), full[OPW], ovf, full[OPW-1:0]};
    endfunction

    // Carry entering byte k = carry out of the low k bytes of a+b+cin.
    function automatic logic model_carry_in(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                            input logic cin, input int k);
        logic [63:0] m;
        logic [63:0] lo;
        m  = (64'd1 << (8 * k)) - 64'd1;
        lo = (64'(a) & m) + (64'(b) & m) + 64'(cin);
        return lo[8*k];
    endfunction

    task automatic sb_compare();
        logic [RW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_rsp got id=%0d sum=%0h exp=none", rsp_id, rsp_sum);
        end else begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e[RW-1 -: IDW]));
            check("rsp_cout", 64'(rsp_cout), 64'(e[OPW+1]));
            check("rsp_sum", 64'(rsp_sum), 64'(e[OPW-1:0]));
`ifdef KSA_SEQ_OVF_EN
            check("rsp_ovf", 64'(rsp_ovf), 64'(e[OPW]));
`endif
        end
    endtask

    // One complete transaction; entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [N_REQ-1:0] mask, input logic [N_REQ-1:0] bg_mask,
                          input int hold, output logic [OPW-1:0] g_sum, output logic g_cout,
                          output logic g_ovf, output int g_id);
        int             g;
        logic [RW-1:0]  e;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
        g = model_grant(mask);
        drive_ops();
        req_valid = mask;
        #1;
        check("req_ready_grant", 64'(req_ready), 64'(N_REQ'(1) << g));
        a   = op_a[g];
        b   = op_b[g];
        cin = op_cin[g];
        e   = model_rsp(g, a, b, cin);
        exp_q.push_back(e);
        rr_ptr = (g + 1) % N_REQ;
        tick();
        req_valid = bg_mask;
        randomize_ops();
        drive_ops();
        for (int k = 0; k < WORDS; k++) begin
            #1;
            check("busy_run", 64'(busy), 64'd1);
            check("req_ready_run", 64'(req_ready), 64'd0);
            check("rsp_valid_run", 64'(rsp_valid), 64'd0);
            check("add_a", 64'(add_a), 64'(a[8*k +: 8]));
            check("add_b", 64'(add_b), 64'(b[8*k +: 8]));
            check("add_cin", 64'(add_cin), 64'(model_carry_in(a, b, cin, k)));
            tick();
        end
        #1;
        check("rsp_valid_latency", 64'(rsp_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            check("rsp_hold_sum", 64'(rsp_sum), 64'(e[OPW-1:0]));
            check("rsp_hold_cout", 64'(rsp_cout), 64'(e[OPW+1]));
            check("rsp_hold_id", 64'(rsp_id), 64'(e[RW-1 -: IDW]));
            check("req_ready_resp", 64'(req_ready), 64'd0);
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("rsp_valid_hs", 64'(rsp_valid), 64'd1);
        check("req_ready_hs", 64'(req_ready), 64'd0);
        g_sum  = rsp_sum;
        g_cout = rsp_cout;
        g_id   = int'(rsp_id);
`ifdef KSA_SEQ_OVF_EN
        g_ovf  = rsp_ovf;
`else
        g_ovf  = 1'b0;
`endif
        sb_compare();
        tick();
        rsp_ready = 1'b0;
        #1;
        check("state_idle_after", 64'(dbg_state), 64'(IDLE));
        check("rsp_valid_after", 64'(rsp_valid), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        if (bg_mask != '0) begin
            check("req_ready_next", 64'(req_ready), 64'(N_REQ'(1) << model_grant(bg_mask)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OPW-1:0] g_sum;
        logic           g_cout;
        logic           g_ovf;
        int             g_id;
        int             accepts;
        int             last;
        int             cyc;

        vt[0] = '{0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vt[1] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[3] = '{1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[4] = '{0, 32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0, 1'b0};
        vt[5] = '{1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[6] = '{0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
        check("reset_rsp_cout", 64'(rsp_cout), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_add", 64'({add_a, add_b, add_cin}), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
`ifdef KSA_SEQ_OVF_EN
        check("reset_rsp_ovf", 64'(rsp_ovf), 64'd0);
`endif

        // Both requesters held valid from reset: grants alternate 0,1,0,1 every WORDS+2 cycles.
        randomize_ops();
        drive_ops();
        req_valid = '1;
        rsp_ready = 1'b1;
        accepts   = 0;
        last      = 0;
        cyc       = 0;
        while ((accepts < 4 || exp_q.size() != 0) && cyc < 80) begin
            #1;
            check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (rsp_valid) sb_compare();
            if (req_ready != '0) begin
                check("rr_alternate", 64'(req_ready), 64'(N_REQ'(1) << (accepts % 2)));
                if (accepts > 0) check("accept_spacing", 64'(cyc - last), 64'(WORDS + 2));
                exp_q.push_back(model_rsp(accepts % 2, op_a[accepts % 2], op_b[accepts % 2],
                                          op_cin[accepts % 2]));
                rr_ptr = ((accepts % 2) + 1) % N_REQ;
                accepts++;
                last = cyc;
            end
            tick();
            if (accepts == 4) req_valid = '0;
            cyc++;
        end
        check("rr_accepts", 64'(accepts), 64'd4);
        check("rr_drain", 64'(exp_q.size()), 64'd0);
        rsp_ready = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) begin
            randomize_ops();
            op_a[vt[i].id]   = vt[i].a;
            op_b[vt[i].id]   = vt[i].b;
            op_cin[vt[i].id] = vt[i].cin;
            run_op(N_REQ'(1) << vt[i].id, '0, 0, g_sum, g_cout, g_ovf, g_id);
            check("vec_sum", 64'(g_sum), 64'(vt[i].sum));
            check("vec_cout", 64'(g_cout), 64'(vt[i].cout));
            check("vec_id", 64'(g_id), 64'(vt[i].id));
`ifdef KSA_SEQ_OVF_EN
            check("vec_ovf", 64'(g_ovf), 64'(vt[i].ovf));
`endif
        end

        // Response back-pressure for 3 cycles with the other requester waiting.
        randomize_ops();
        run_op(2'b01, 2'b10, 3, g_sum, g_cout, g_ovf, g_id);
        randomize_ops();
        run_op(2'b10, 2'b00, 0, g_sum, g_cout, g_ovf, g_id);

        // Abort in RUN at byte index 2: back to IDLE, pointer 0, no response.
        randomize_ops();
        drive_ops();
        req_valid = 2'b01;
        #1;
        check("abort_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        check("abort_idx2_add_a", 64'(add_a), 64'(op_a[0][23:16]));
        check("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        rr_ptr = 0;
        #1;
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_busy_low", 64'(busy), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_add", 64'({add_a, add_b, add_cin}), 64'd0);
        check("abort_rsp_fields", 64'({rsp_sum, rsp_cout, rsp_id}), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd0);
        for (int n = 0; n < 8; n++) begin
            tick();
            #1;
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        randomize_ops();
        run_op(2'b11, 2'b00, 0, g_sum, g_cout, g_ovf, g_id);
        check("ptr_reset_grant", 64'(g_id), 64'd0);

        // Randomized traffic against the arithmetic and round-robin reference.
        for (int n = 0; n < 40; n++) begin
            randomize_ops();
            run_op(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)),
                   N_REQ'($urandom_range(0, (1 << N_REQ) - 1)),
                   $urandom_range(0, 3), g_sum, g_cout, g_ovf, g_id);
        end

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ksa_word_seq_arb.md
Name: ksa_word_seq_arb

Overview:
- Controller that shares one external 8-bit carry-in/carry-out adder datapath between N_REQ requesters.
- Performs WORDS-byte additions serially, one byte per cycle, LSB first, with a registered inter-byte carry.
- Sits in front of the 8-bit prefix adder instance, which stays purely combinational.
- Arbitrates requesters round-robin, sequences the byte passes and returns one response per accepted request.

Parameters:
- WORDS, 4, operand width in bytes; operand width OPW = 8*WORDS; legal range 1..16.
- N_REQ, 2, number of requesters; legal range 2..8; IDW = max(1, clog2(N_REQ)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_a  in  N_REQ*OPW  operand A; requester i occupies bits [i*OPW +: OPW].
- req_b  in  N_REQ*OPW  operand B; same packing as req_a.
- req_cin  in  N_REQ  carry-in per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_sum  out  OPW  sum.
- rsp_cout  out  1  final carry out.
- busy  out  1  high in RUN or RESP.
- add_a  out  8  byte to adder A input.
- add_b  out  8  byte to adder B input.
- add_cin  out  1  adder carry-in.
- add_sum  in  8  adder sum, combinational return.
- add_cout  in  1  adder carry-out, combinational return.

Behaviour:
- Reset: state IDLE; all outputs 0; internal operand/sum/carry regs 0; byte index 0; round-robin pointer 0 (requester 0 has top priority first).
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant = first asserted req_valid scanning from the pointer upward, with wrap.
  - req_ready[grant] = 1 combinationally in the same cycle. Accept = req_valid & req_ready.
  - On accept, capture a, b, cin and id; index <= 0; pointer <= grant+1 mod N_REQ; next state RUN.
  - No request pending: stay in IDLE, pointer unchanged.
- RUN:
  - add_a = a_reg byte[index]; add_b = b_reg byte[index]; add_cin = carry_reg, which is initialised from the captured cin.
  - Each cycle: sum_reg byte[index] <= add_sum; carry_reg <= add_cout; index++.
  - When index == WORDS-1, next state is RESP.
  - Outside RUN, add_a, add_b and add_cin are driven 0.
- RESP:
  - rsp_valid = 1 with rsp_sum, rsp_cout and rsp_id held stable until rsp_ready.
  - On handshake, next state is IDLE. No new accept in the handshake cycle.
- Timing:
  - Accept at cycle T gives rsp_valid at T+WORDS+1.
  - Minimum spacing between accepts is WORDS+2 cycles.
- req_ready is 0 in RUN and RESP. A requester dropping req_valid before grant loses nothing; requests are sampled only at grant.
- Arithmetic is modulo 2^OPW; rsp_cout is the carry-out of the top byte.
- Reset asserted in any state aborts the operation on the next edge; no response is emitted.

Optional Feature:
- Macro KSA_SEQ_OVF_EN.
- Defined: adds output rsp_ovf (1 bit), the two's-complement overflow = (a[OPW-1]==b[OPW-1]) && (sum[OPW-1]!=a[OPW-1]). It is registered with the final byte, is valid with rsp_valid, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ksa_seq_pkg holds:
  - the state enum {IDLE, RUN, RESP};
  - BYTE_W = 8;
  - a function computing IDW from N_REQ.
- One sub-module, rr_arbiter: N_REQ-wide, pointer-based, one-hot grant, with an update-on-accept input.

Test Plan:
1. WORDS=4. Req0: a=0x000000FF, b=0x00000001, cin=0, rsp_ready=1 -> rsp_valid at T+5, sum=0x00000100, cout=0, id=0.
2. Req1: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, id=1. Check add_cin sequence across the four RUN cycles: 1,1,1,1.
3. Both req_valid held high from reset for four operations -> grants alternate 0,1,0,1. req_ready is never high for two requesters at once.
4. rsp_ready held 0 for 3 cycles in RESP -> rsp fields stable, req_ready stays 0. On the handshake cycle the state returns to IDLE; the next accept occurs one cycle later.
5. rst pulsed in RUN with index=2 -> next cycle: IDLE, all outputs 0, pointer 0. No rsp_valid is ever raised for the aborted operation.
6. With KSA_SEQ_OVF_EN defined: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, rsp_ovf=1. With a=0xFFFFFFFF, b=0x00000001 -> rsp_ovf=0.
